fpu_inflight_tracker: RTL

Producer side of the FP in-flight hazard interface. It records the destination register of every pipelined FP op (FADD/FSUB, FMUL, FMA family) as the op enters EX, and holds it for the op's fixed latency. It drives the six `fpu_inflight_dest_*` fields of the EX combinational bundle that the hazard resolution unit consumes. It sits in EX beside the FPU and owns the countdown scoreboard.

---
 rtl/fpu_inflight_tracker_if.sv | 34 +++
 rtl/fpu_inflight_tracker.sv | 113 +++++++++++
 2 files changed

// File: rtl/fpu_inflight_tracker_if.sv
// Issue-side inputs and in-flight hazard bundle between the EX issue logic and the FP in-flight tracker.
// Latency: none (wires only). Backpressure: none; the stall and overflow semantics live in the tracker.
interface fpu_inflight_tracker_if;
    logic       i_issue_valid;
    logic [1:0] i_issue_op_class;
    logic [4:0] i_issue_dest;
    logic       i_stall_registered;
    logic       i_flush;

    logic [4:0] o_fpu_inflight_dest_1;
    logic [4:0] o_fpu_inflight_dest_2;
    logic [4:0] o_fpu_inflight_dest_3;
    logic [4:0] o_fpu_inflight_dest_4;
    logic [4:0] o_fpu_inflight_dest_5;
    logic [4:0] o_fpu_inflight_dest_6;
    logic [5:0] o_inflight_valid;
    logic [5:0] o_retire_mask;
    logic       o_full;
    logic       o_overflow_error;

    modport master (
        output i_issue_valid, i_issue_op_class, i_issue_dest, i_stall_registered, i_flush,
        input  o_fpu_inflight_dest_1, o_fpu_inflight_dest_2, o_fpu_inflight_dest_3,
               o_fpu_inflight_dest_4, o_fpu_inflight_dest_5, o_fpu_inflight_dest_6,
               o_inflight_valid, o_retire_mask, o_full, o_overflow_error
    );

    modport slave (
        input  i_issue_valid, i_issue_op_class, i_issue_dest, i_stall_registered, i_flush,
        output o_fpu_inflight_dest_1, o_fpu_inflight_dest_2, o_fpu_inflight_dest_3,
               o_fpu_inflight_dest_4, o_fpu_inflight_dest_5, o_fpu_inflight_dest_6,
               o_inflight_valid, o_retire_mask, o_full, o_overflow_error
    );
endinterface

// File: rtl/fpu_inflight_tracker.sv
// Six-slot countdown scoreboard of FP destinations in flight; an entry is visible one cycle after EX entry.
// Backpressure: issues while full are dropped and latch a sticky overflow error; stalled issues are ignored.
module fpu_inflight_tracker #(
    parameter int ADD_LATENCY = 4,
    parameter int MUL_LATENCY = 4,
    parameter int FMA_LATENCY = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fpu_inflight_tracker_if.slave bus
);
    localparam int SLOTS = 6;
    localparam logic [3:0] ADD_LAT = 4'(ADD_LATENCY);
    localparam logic [3:0] MUL_LAT = 4'(MUL_LATENCY);
    localparam logic [3:0] FMA_LAT = 4'(FMA_LATENCY);

    logic [3:0] cnt_q  [SLOTS];
    logic [3:0] cnt_d  [SLOTS];
    logic [4:0] dest_q [SLOTS];
    logic [4:0] dest_d [SLOTS];
    logic       ovf_q;
    logic       ovf_d;

    logic [5:0] valid;
    logic [5:0] retiring;
    logic [5:0] free;
    logic       full;
    logic       accept;
    logic       overflow;
    logic       alloc_hit;
    logic [2:0] alloc_idx;
    logic [3:0] issue_lat;

    always_comb begin
        for (int k = 0; k < SLOTS; k++) begin
            valid[k]    = (cnt_q[k] != 4'd0);
            retiring[k] = (cnt_q[k] == 4'd1);
        end
        // A retiring slot frees at the same edge, so it can take the new issue directly.
        free = ~valid | retiring;
        full = ~|free;
    end

    always_comb begin
        case (bus.i_issue_op_class)
            2'b00:   issue_lat = ADD_LAT;
            2'b01:   issue_lat = MUL_LAT;
            default: issue_lat = FMA_LAT;
        endcase
    end

    assign accept   = bus.i_issue_valid & ~bus.i_stall_registered & ~bus.i_flush;
    assign overflow = accept & full;

    always_comb begin
        alloc_hit = 1'b0;
        alloc_idx = 3'd0;
        for (int k = SLOTS - 1; k >= 0; k--) begin
            if (free[k]) begin
                alloc_hit = 1'b1;
                alloc_idx = 3'(k);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < SLOTS; k++) begin
            cnt_d[k]  = cnt_q[k];
            dest_d[k] = dest_q[k];
            if (bus.i_flush) begin
                cnt_d[k]  = 4'd0;
                dest_d[k] = 5'd0;
            end else if (accept && alloc_hit && (alloc_idx == 3'(k))) begin
                cnt_d[k]  = issue_lat;
                dest_d[k] = bus.i_issue_dest;
            end else if (valid[k]) begin
                // The FPU pipe free-runs, so countdown ignores stall.
                cnt_d[k] = cnt_q[k] - 4'd1;
                if (retiring[k]) begin
                    dest_d[k] = 5'd0;
                end
            end
        end
        ovf_d = ovf_q | overflow;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < SLOTS; k++) begin
                cnt_q[k]  <= 4'd0;
                dest_q[k] <= 5'd0;
            end
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < SLOTS; k++) begin
                cnt_q[k]  <= cnt_d[k];
                dest_q[k] <= dest_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign bus.o_fpu_inflight_dest_1 = dest_q[0];
    assign bus.o_fpu_inflight_dest_2 = dest_q[1];
    assign bus.o_fpu_inflight_dest_3 = dest_q[2];
    assign bus.o_fpu_inflight_dest_4 = dest_q[3];
    assign bus.o_fpu_inflight_dest_5 = dest_q[4];
    assign bus.o_fpu_inflight_dest_6 = dest_q[5];
    assign bus.o_inflight_valid      = valid;
    assign bus.o_retire_mask         = retiring & ~{SLOTS{bus.i_flush}};
    assign bus.o_full                = full;
    assign bus.o_overflow_error      = ovf_q;
endmodule
